// File: rtl/uart_rx_sipo_pkg.sv
// Shared UART Rx constants: FSM encodings, frame geometry and bit positions, also used by the de-framing stage.
// No logic; nothing to clock. Build option: UART_RX_MAJORITY_EN selects the 3-sample bit vote.
package uart_rx_sipo_pkg;

  localparam int FRAME_BITS     = 11;
  localparam int OVERSAMPLE_DEF = 16;

  localparam int START_IDX  = 10;
  localparam int PARITY_IDX = 1;
  localparam int STOP_IDX   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  // Field view of data_parll as the de-framing stage decodes it (data LSB sits at the high end).
  typedef struct packed {
    logic       start_bit;
    logic [7:0] data_rev;
    logic       parity_bit;
    logic       stop_bit;
  } frame_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Rx line conditioner: 2-FF synchronizer; with UART_RX_MAJORITY_EN also a 2-of-3 vote over the last three ticks.
// Latency: 2 clocks to rx_s; the vote covers the current tick and the two before it.
// Backpressure: none, free-running.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
`ifdef UART_RX_MAJORITY_EN
  input  logic baud_tick,
`endif
  input  logic rx_in,
  output logic rx_s,
  output logic bit_val
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rx_in;
      sync_q2 <= sync_q1;
    end
  end

  assign rx_s = sync_q2;

`ifdef UART_RX_MAJORITY_EN
  logic hist1;
  logic hist2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else if (baud_tick) begin
      hist1 <= sync_q2;
      hist2 <= hist1;
    end
  end

  assign bit_val = (hist2 & hist1) | (hist2 & sync_q2) | (hist1 & sync_q2);
`else
  assign bit_val = sync_q2;
`endif

endmodule

// File: rtl/uart_rx_sipo.sv
// UART Rx front end: start-bit hunt, mid-bit sampling, 11-bit serial-to-parallel capture (UART_RX_MAJORITY_EN: voted bits).
// Latency: 2 clocks + (OVERSAMPLE/2 + 10*OVERSAMPLE) ticks from start edge to recieved_flag (+1 tick with voting).
// Backpressure: none; a new start edge overwrites the flag, the next completion overwrites data_parll.
module uart_rx_sipo
  import uart_rx_sipo_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  output logic [FRAME_BITS-1:0] data_parll,
  output logic                  recieved_flag,
  output logic                  active_flag
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] WRAP = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] SAMPLE_PT = MID + 1'b1;
`else
  localparam logic [TW-1:0] SAMPLE_PT = MID;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic                  rx_s;
  logic                  bit_val;
  logic [1:0]            state;
  logic [TW-1:0]         tick_cnt;
  logic [3:0]            bit_cnt;
  logic                  prev;
  logic [FRAME_BITS-2:0] shreg;

  uart_rx_sync u_sync (
    .clock     (clock),
    .reset     (reset),
`ifdef UART_RX_MAJORITY_EN
    .baud_tick (baud_tick),
`endif
    .rx_in     (rx_in),
    .rx_s      (rx_s),
    .bit_val   (bit_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      prev          <= 1'b1;
      shreg         <= '1;
      data_parll    <= '1;
      recieved_flag <= 1'b0;
      active_flag   <= 1'b0;
    end else if (baud_tick) begin
      case (state)
        ST_IDLE: begin
          prev <= rx_s;
          if (prev && !rx_s) begin
            state         <= ST_START;
            active_flag   <= 1'b1;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            recieved_flag <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_cnt == SAMPLE_PT) begin
            tick_cnt <= '0;
            if (bit_val) begin
              // Line back high at mid start bit: treat as a glitch and re-arm.
              state       <= ST_IDLE;
              active_flag <= 1'b0;
              prev        <= bit_val;
            end else begin
              shreg   <= {shreg[FRAME_BITS-3:0], bit_val};
              bit_cnt <= 4'd1;
              state   <= ST_DATA;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == WRAP) begin
            tick_cnt <= '0;
            shreg    <= {shreg[FRAME_BITS-3:0], bit_val};
            if (bit_cnt == LAST_BIT) begin
              // Stop bit delivered as sampled; a low stop leaves prev=0 so IDLE waits for the line to rise.
              data_parll    <= {shreg, bit_val};
              recieved_flag <= 1'b1;
              state         <= ST_IDLE;
              active_flag   <= 1'b0;
              prev          <= bit_val;
              bit_cnt       <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: OVERSAMPLE=16, baud_tick every 4th clock, 64 clocks per bit.
// Build with UART_RX_MAJORITY_EN to exercise the voted-sample variant.
module tb_uart_rx_sipo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx_in = 1'b1;
  logic [10:0] data_parll;
  logic        recieved_flag;
  logic        active_flag;

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;

  always #5 clock = ~clock;

  uart_rx_sipo dut (
    .clock         (clock),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .data_parll    (data_parll),
    .recieved_flag (recieved_flag),
    .active_flag   (active_flag)
  );

  task automatic check_vec(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step(input logic rx);
    @(posedge clock);
    #1;
    phase     = (phase + 1) % 4;
    baud_tick = (phase == 0);
    rx_in     = rx;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1);
  endtask

  // Aligned frames put the receiver's start-edge tick 2 clocks after the line falls, so the
  // mid-bit sample sees clock 32 of each 64-clock bit (28/32/36 when voting).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input bit align, input bit glitch, input int abort_bit);
    logic [10:0] fb;
    logic        v;
    fb = {stp, par, d, 1'b0};
    if (align) while (phase != 1) step(1'b1);
    for (int i = 0; i < 11; i++) begin
      if (i == abort_bit) return;
      for (int k = 0; k < 64; k++) begin
        v = fb[i];
        if (glitch && i >= 1 && i <= 8 && k >= 31 && k <= 34) v = ~v;
        step(v);
        if (i == 3 && k == 40) begin
          check_vec("active_in_frame", 11'(active_flag), 11'd1);
          check_vec("flag_cleared_in_frame", 11'(recieved_flag), 11'd0);
        end
      end
    end
  endtask

  initial begin
    repeat (3) step(1'b1);
    check_vec("reset_data", data_parll, 11'h7FF);
    check_vec("reset_flag", 11'(recieved_flag), 11'd0);
    check_vec("reset_active", 11'(active_flag), 11'd0);
    reset = 1'b0;
    idle(100);

    // 1: 0x5A, parity 0, stop 1
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 99);
    check_vec("f5a_data", data_parll, 11'b0_01011010_0_1);
    check_vec("f5a_flag", 11'(recieved_flag), 11'd1);
    check_vec("f5a_active", 11'(active_flag), 11'd0);

    // 2: 3-tick low pulse is rejected at mid start bit
    idle(64);
    while (phase != 1) step(1'b1);
    repeat (12) step(1'b0);
    repeat (3) step(1'b1);
    check_vec("glitch_start_active", 11'(active_flag), 11'd1);
    idle(60);
    check_vec("glitch_rejected_active", 11'(active_flag), 11'd0);
    check_vec("glitch_flag", 11'(recieved_flag), 11'd0);
    check_vec("glitch_data_kept", data_parll, 11'b0_01011010_0_1);

    // 3: framing error, line stays low afterwards
    idle(64);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    check_vec("fe_data", data_parll, 11'b0_11111111_0_0);
    check_vec("fe_flag", 11'(recieved_flag), 11'd1);
    repeat (200) step(1'b0);
    check_vec("fe_low_active", 11'(active_flag), 11'd0);
    check_vec("fe_low_flag", 11'(recieved_flag), 11'd1);
    check_vec("fe_low_data", data_parll, 11'b0_11111111_0_0);
    idle(128);

    // 4: back-to-back 0x01 then 0x80 (parity 1 each)
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 99);
    check_vec("b2b1_data", data_parll, 11'b0_10000000_1_1);
    check_vec("b2b1_flag", 11'(recieved_flag), 11'd1);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 99);
    check_vec("b2b2_data", data_parll, 11'b0_00000001_1_1);
    check_vec("b2b2_flag", 11'(recieved_flag), 11'd1);

    // 5: reset at start of bit 5, then a clean 0x3C
    idle(64);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 5);
    reset = 1'b1;
    #1;
    check_vec("midreset_data", data_parll, 11'h7FF);
    check_vec("midreset_flag", 11'(recieved_flag), 11'd0);
    check_vec("midreset_active", 11'(active_flag), 11'd0);
    repeat (4) step(1'b1);
    reset = 1'b0;
    idle(100);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 99);
    check_vec("f3c_data", data_parll, 11'b0_00111100_0_1);
    check_vec("f3c_flag", 11'(recieved_flag), 11'd1);

    // 6: one-tick high glitch at mid of each data bit of 0x00
    idle(64);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 99);
`ifdef UART_RX_MAJORITY_EN
    check_vec("midglitch_data", data_parll, 11'b0_00000000_0_1);
`else
    check_vec("midglitch_data", data_parll, 11'b0_11111111_0_1);
`endif
    check_vec("midglitch_flag", 11'(recieved_flag), 11'd1);
    idle(32);
    check_vec("final_active", 11'(active_flag), 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
